// File: rtl/conv_pkg.sv
// Shared definitions for the conv/FC datapath family: field widths and
// saturation bounds for an N-bit signed result.
package conv_pkg;

    localparam int SHIFT_W = 5;
    localparam int BIAS_W  = 32;

    function automatic int sat_max(input int n);
        return (1 << (n - 1)) - 1;
    endfunction

    function automatic int sat_min(input int n);
        return -(1 << (n - 1));
    endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational requantiser: optional round-half-up, arithmetic right shift,
// then clamp to the signed N-bit range or to [0, MAX] when relu_en is set.
module requant_sat
    import conv_pkg::*;
#(
    parameter int N     = 8,
    parameter int ACC_W = 32,
    parameter int ROUND = 1
) (
    input  logic [ACC_W-1:0]   acc,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               relu_en,
    output logic [N-1:0]       dout
);

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(N));
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(N));

    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] lo;
    logic signed [ACC_W-1:0] clamped;

    always_comb begin
        rnd = '0;
        if (ROUND != 0 && shift != '0) begin
            rnd = ACC_W'(1) << (shift - SHIFT_W'(1));
        end
        // sum wraps at ACC_W like the accumulator does
        sum     = $signed(acc) + rnd;
        shifted = sum >>> shift;
        lo      = relu_en ? '0 : MIN_V;
        clamped = shifted;
        if (shifted > MAX_V) begin
            clamped = MAX_V;
        end else if (shifted < lo) begin
            clamped = lo;
        end
        dout = clamped[N-1:0];
    end

endmodule

// File: rtl/conv_unit_k1_mc.sv
// Pointwise (1x1) convolution unit: three-stage product / accumulate / requant
// pipeline with a single global stall driven by the output handshake.
module conv_unit_k1_mc
    import conv_pkg::*;
#(
    parameter int N          = 8,
    parameter int CH_IN      = 4,
    parameter int INPUT_SIZE = 6,
    parameter int ACC_W      = 32,
    parameter int ROUND      = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [N-1:0]       input_din,
    input  logic [N-1:0]       weight_din,
    input  logic [BIAS_W-1:0]  bias_din,
    input  logic [SHIFT_W-1:0] shift_din,
    input  logic               relu_en,
    output logic [N-1:0]       conv_dout,
    output logic               conv_dout_vld,
    input  logic               conv_dout_rdy,
    output logic               conv_dout_last,
    output logic               busy
);

    localparam int FRAME = INPUT_SIZE * INPUT_SIZE;
    localparam int CH_W  = (CH_IN > 1) ? $clog2(CH_IN) : 1;
    localparam int PIX_W = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH_IN - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(FRAME - 1);

    logic             en;
    logic             rdy_q;
    logic             beat;
    logic             ch_first;
    logic             ch_last;
    logic [CH_W-1:0]  ch_cnt;
    logic [PIX_W-1:0] pix_cnt;

    logic                      s1_vld;
    logic signed [2*N-1:0]     s1_prod;
    logic                      s1_first;
    logic                      s1_last;
    logic signed [BIAS_W-1:0]  s1_bias;
    logic [SHIFT_W-1:0]        s1_shift;
    logic                      s1_relu;

    logic                      s2_vld;
    logic                      s2_last;
    logic signed [ACC_W-1:0]   acc;
    logic [SHIFT_W-1:0]        s2_shift;
    logic                      s2_relu;

    logic [N-1:0]              rq_dout;

    assign en       = !conv_dout_vld || conv_dout_rdy;
    // rdy_q keeps in_rdy low while reset is asserted
    assign in_rdy   = rdy_q && en;
    assign beat     = in_vld && in_rdy;
    assign ch_first = (ch_cnt == '0);
    assign ch_last  = (ch_cnt == CH_LAST);

    assign conv_dout_last = conv_dout_vld && (pix_cnt == PIX_LAST);
    assign busy           = (ch_cnt != '0) || s1_vld || s2_vld || conv_dout_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt <= '0;
        end else if (beat) begin
            ch_cnt <= ch_last ? '0 : ch_cnt + CH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt <= '0;
        end else if (conv_dout_vld && conv_dout_rdy) begin
            pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + PIX_W'(1);
        end
    end

    // Stage 1: product plus per-beat tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_prod  <= '0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_bias  <= '0;
            s1_shift <= '0;
            s1_relu  <= 1'b0;
        end else if (en) begin
            s1_vld <= beat;
            if (beat) begin
                s1_prod  <= $signed(input_din) * $signed(weight_din);
                s1_first <= ch_first;
                s1_last  <= ch_last;
                s1_bias  <= $signed(bias_din);
                s1_shift <= shift_din;
                s1_relu  <= relu_en;
            end
        end
    end

    // Stage 2: accumulate; requant controls are taken from the channel-0 beat only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld   <= 1'b0;
            s2_last  <= 1'b0;
            acc      <= '0;
            s2_shift <= '0;
            s2_relu  <= 1'b0;
        end else if (en) begin
            s2_vld  <= s1_vld;
            s2_last <= s1_vld && s1_last;
            if (s1_vld) begin
                if (s1_first) begin
                    acc      <= ACC_W'(s1_bias) + ACC_W'(s1_prod);
                    s2_shift <= s1_shift;
                    s2_relu  <= s1_relu;
                end else begin
                    acc <= acc + ACC_W'(s1_prod);
                end
            end
        end
    end

    requant_sat #(
        .N     (N),
        .ACC_W (ACC_W),
        .ROUND (ROUND)
    ) u_requant (
        .acc     (acc),
        .shift   (s2_shift),
        .relu_en (s2_relu),
        .dout    (rq_dout)
    );

    // Stage 3: output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_dout     <= '0;
            conv_dout_vld <= 1'b0;
        end else if (en) begin
            conv_dout_vld <= s2_vld && s2_last;
            if (s2_vld && s2_last) begin
                conv_dout <= rq_dout;
            end
        end
    end

endmodule

// File: doc/conv_unit_k1_mc.md
Name: conv_unit_k1_mc

Overview:
- Next-generation 1x1 (pointwise) convolution unit. Accumulates CH_IN serial channel products per output pixel, then adds bias and requantises with an arithmetic shift, optional rounding, saturation and a selectable ReLU.
- Full valid/ready handshake on both sides, so it chains between line-buffer feeders and downstream pooling/FC stages.
- Flags the last pixel of each INPUT_SIZE x INPUT_SIZE feature map.

Parameters:
- N, 8: signed width of activations, weights and output.
- CH_IN, 4: input channels accumulated per output pixel (>=1).
- INPUT_SIZE, 6: feature-map side; frame = INPUT_SIZE*INPUT_SIZE pixels.
- ACC_W, 32: signed accumulator width (>= 2N + clog2(CH_IN) + 1).
- ROUND, 1: 1 = round-half-up before shift; 0 = truncate.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- in_vld  in  1  input beat valid
- in_rdy  out  1  unit can accept a beat
- input_din  in  N  signed activation, one channel per beat
- weight_din  in  N  signed weight for the same channel
- bias_din  in  32  signed bias; sampled on a pixel's channel-0 beat
- shift_din  in  5  right-shift amount 0..31; sampled on channel-0 beat
- relu_en  in  1  1 = clamp to [0,MAX]; 0 = clamp to [-(MAX+1),MAX]; sampled on channel-0 beat
- conv_dout  out  N  signed result
- conv_dout_vld  out  1  result valid
- conv_dout_rdy  in  1  downstream accepts result
- conv_dout_last  out  1  qualifies the last pixel of a frame
- busy  out  1  any pixel partially accumulated or in flight

Behaviour:
- Reset: every register cleared. in_rdy=0 during reset, then 1. conv_dout=0, conv_dout_vld=0, conv_dout_last=0, busy=0. Channel and pixel counters=0.
- MAX = 2^(N-1)-1 (localparam).
- Stall: global enable en = !conv_dout_vld || conv_dout_rdy. in_rdy = en. Beats transfer when in_vld && in_rdy. All pipeline stages hold when en=0. No beat is dropped or duplicated.
- Stage 1 (product register): prod = signed input_din * weight_din (2N bits), tagged with first/last-channel flags and the sampled bias/shift/relu.
- Stage 2 (accumulator):
  - On a first-channel beat: acc = sext(bias) + sext(prod).
  - Otherwise: acc += sext(prod).
  - Accumulator wraps on overflow; sizing via ACC_W prevents overflow.
- Stage 3 (requant, output register), on a last-channel beat:
  - r = (acc + (ROUND && shift>0 ? 1<<(shift-1) : 0)) >>> shift. Arithmetic shift, ACC_W wide.
  - Clamp r to the range selected by relu_en. Register into conv_dout and set conv_dout_vld.
- Latency: last-channel beat accepted at cycle t -> conv_dout_vld at t+3 with no stall. Throughput is one beat per cycle, i.e. one pixel per CH_IN cycles.
- Channel counter 0..CH_IN-1:
  - Increments per accepted beat and wraps to 0 after CH_IN-1.
  - CH_IN=1: every beat is both first and last channel.
- conv_dout_vld stays high with conv_dout stable until conv_dout_rdy. It drops the cycle after acceptance unless a new result arrives in that same cycle.
- Pixel counter 0..INPUT_SIZE^2-1:
  - Increments per accepted output.
  - conv_dout_last=1 with the pixel at count INPUT_SIZE^2-1; the counter then wraps to 0. Back-to-back frames need no gap.
- busy = (channel counter != 0) || any stage valid.
- Asynchronous reset mid-pixel discards partial sums. The next accepted beat is channel 0 of a new pixel at pixel count 0.

Decomposition:
- Shared package conv_pkg:
  - saturation-range helpers: MAX, MIN as functions of N.
  - localparam SHIFT_W=5; bias width 32.
- Natural sub-module: requant_sat. Combinational round/shift/clamp, parameters N and ACC_W. Reusable by later conv/FC units.

Test Plan:
- N=8, CH_IN=4, bias=0, shift=0, relu_en=1; inputs 10,20,30,40, weights 1,2,3,4 -> sum 300 -> conv_dout=127, 3 cycles after the 4th beat.
- Same operands, ROUND=1: shift=2 -> 75; shift=3 -> (300+4)>>>3 = 38. ROUND=0, shift=3 -> 37.
- Inputs -10 x4, weights 5 x4, bias 8 (sum -192), shift 0:
  - relu_en=0 -> -128.
  - relu_en=1 -> 0.
  - shift 1, relu_en=0, ROUND=1 -> (-192+1)>>>1 = -96.
- Backpressure with three pixels streamed: hold conv_dout_rdy=0 for 5 cycles while valid -> in_rdy=0 within one cycle, conv_dout stable, all three results later emerge in order with correct values.
- INPUT_SIZE=2, 9 pixels streamed continuously -> conv_dout_last high on outputs 4 and 8 only; output 9 has last=0.
- Assert rst_n low after 2 channels of a pixel -> outputs 0 immediately, busy=0. A subsequent 4 beats give the correct fresh result with pixel count restarting (last on 4th output when INPUT_SIZE=2).
